// File: rtl/lease_lookup_table_dbuf.sv
// Double-buffered lease lookup table: loader fills the shadow bank while the
// active bank serves single-cycle registered lookups; a swap handshake exchanges them.
module lease_lookup_table_dbuf #(
    parameter int N_ENTRIES         = 128,
    parameter int BW_REF_ADDR       = 30,
    parameter int BW_LEASE_REGISTER = 32,
    parameter int BW_PROB           = 9,
    parameter int BW_COUNT          = 32,
    localparam int BW_ENTRIES       = $clog2(N_ENTRIES)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [BW_ENTRIES+1:0]        addr_i,
    input  logic                         wren_i,
    input  logic [31:0]                  data_i,
    input  logic [BW_ENTRIES:0]          phase_refs_i,
    input  logic                         swap_req_i,
    output logic                         swap_ack_o,
    input  logic                         search_req_i,
    input  logic [BW_REF_ADDR-1:0]       search_addr_i,
    output logic                         search_valid_o,
    output logic                         hit_o,
    output logic [BW_ENTRIES-1:0]        hit_index_o,
    output logic [BW_LEASE_REGISTER-1:0] lease0_o,
    output logic [BW_LEASE_REGISTER-1:0] lease1_o,
    output logic [BW_PROB-1:0]           lease0_prob_o,
    output logic                         active_bank_o,
    output logic [BW_COUNT-1:0]          hit_count_o,
    output logic [BW_COUNT-1:0]          miss_count_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SWAP = 1'b1;

    logic [BW_REF_ADDR-1:0]       ref_mem    [2][N_ENTRIES];
    logic [BW_LEASE_REGISTER-1:0] lease0_mem [2][N_ENTRIES];
    logic [BW_LEASE_REGISTER-1:0] lease1_mem [2][N_ENTRIES];
    logic [BW_PROB-1:0]           prob_mem   [2][N_ENTRIES];
    logic [N_ENTRIES-1:0]         valid_q    [2];

    logic                  state_q;
    logic                  armed_q;
    logic [1:0]            field_sel;
    logic [BW_ENTRIES-1:0] wr_idx;
    logic                  shadow;
    logic                  wr_in_phase;
    logic                  match_found;
    logic [BW_ENTRIES-1:0] match_idx;
    logic                  data_unused;

    assign field_sel   = addr_i[BW_ENTRIES +: 2];
    assign wr_idx      = addr_i[BW_ENTRIES-1:0];
    assign shadow      = ~active_bank_o;
    assign wr_in_phase = ({1'b0, wr_idx} < phase_refs_i);
    assign data_unused = &{1'b0, data_i[1:0]};

    // Entry payload is never reset; only the valid bits gate visibility.
    always_ff @(posedge clock_i) begin
        if (!reset_i && wren_i) begin
            case (field_sel)
                2'd0:    ref_mem[shadow][wr_idx]    <= data_i[BW_REF_ADDR+1:2];
                2'd1:    lease0_mem[shadow][wr_idx] <= data_i[BW_LEASE_REGISTER-1:0];
                2'd2:    lease1_mem[shadow][wr_idx] <= data_i[BW_LEASE_REGISTER-1:0];
                default: prob_mem[shadow][wr_idx]   <= data_i[BW_PROB-1:0];
            endcase
        end
    end

    // Lowest matching index wins.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (!match_found && valid_q[active_bank_o][i] &&
                (ref_mem[active_bank_o][i] == search_addr_i)) begin
                match_found = 1'b1;
                match_idx   = BW_ENTRIES'(i);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            armed_q        <= 1'b1;
            active_bank_o  <= 1'b0;
            swap_ack_o     <= 1'b0;
            valid_q[0]     <= '0;
            valid_q[1]     <= '0;
            search_valid_o <= 1'b0;
            hit_o          <= 1'b0;
            hit_index_o    <= '0;
            lease0_o       <= '0;
            lease1_o       <= '0;
            lease0_prob_o  <= '0;
            hit_count_o    <= '0;
            miss_count_o   <= '0;
        end else begin
            swap_ack_o     <= (state_q == ST_SWAP);
            search_valid_o <= search_req_i;
            if (search_req_i) begin
                hit_o         <= match_found;
                hit_index_o   <= match_found ? match_idx : '0;
                lease0_o      <= match_found ? lease0_mem[active_bank_o][match_idx] : '0;
                lease1_o      <= match_found ? lease1_mem[active_bank_o][match_idx] : '0;
                lease0_prob_o <= match_found ? prob_mem[active_bank_o][match_idx] : '0;
            end

            if (wren_i && (field_sel == 2'd0)) begin
                valid_q[shadow][wr_idx] <= wr_in_phase;
            end

            // A new swap needs swap_req_i to have been seen low since the last one.
            case (state_q)
                ST_IDLE: begin
                    if (swap_req_i && armed_q) begin
                        state_q <= ST_SWAP;
                        armed_q <= 1'b0;
                    end else if (!swap_req_i) begin
                        armed_q <= 1'b1;
                    end
                end
                default: begin
                    state_q                <= ST_IDLE;
                    active_bank_o          <= ~active_bank_o;
                    valid_q[active_bank_o] <= '0;
                    if (!swap_req_i) begin
                        armed_q <= 1'b1;
                    end
                end
            endcase

            // The swap clear overrides any increment landing on the same edge.
            if (state_q == ST_SWAP) begin
                hit_count_o  <= '0;
                miss_count_o <= '0;
            end else if (search_req_i) begin
                if (match_found) begin
                    if (hit_count_o != '1) begin
                        hit_count_o <= hit_count_o + BW_COUNT'(1);
                    end
                end else begin
                    if (miss_count_o != '1) begin
                        miss_count_o <= miss_count_o + BW_COUNT'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lease_lookup_table_dbuf.sv
// Bench for lease_lookup_table_dbuf: transaction-level bank model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_lease_lookup_table_dbuf;

    localparam int N   = 16;
    localparam int BWE = 4;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [BWE+1:0] addr_i = '0;
    logic         wren_i = 1'b0;
    logic [31:0]  data_i = '0;
    logic [BWE:0] phase_refs_i = '0;
    logic         swap_req_i = 1'b0;
    logic         swap_ack_o;
    logic         search_req_i = 1'b0;
    logic [29:0]  search_addr_i = '0;
    logic         search_valid_o;
    logic         hit_o;
    logic [BWE-1:0] hit_index_o;
    logic [31:0]  lease0_o;
    logic [31:0]  lease1_o;
    logic [8:0]   lease0_prob_o;
    logic         active_bank_o;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    always #5 clk = ~clk;

    lease_lookup_table_dbuf #(.N_ENTRIES(N)) dut (
        .clock_i(clk), .reset_i(reset_i), .addr_i(addr_i), .wren_i(wren_i),
        .data_i(data_i), .phase_refs_i(phase_refs_i), .swap_req_i(swap_req_i),
        .swap_ack_o(swap_ack_o), .search_req_i(search_req_i),
        .search_addr_i(search_addr_i), .search_valid_o(search_valid_o),
        .hit_o(hit_o), .hit_index_o(hit_index_o), .lease0_o(lease0_o),
        .lease1_o(lease1_o), .lease0_prob_o(lease0_prob_o),
        .active_bank_o(active_bank_o), .hit_count_o(hit_count_o),
        .miss_count_o(miss_count_o)
    );

    // Reference model: two banks of entries plus the expected output values.
    longint m_ref [2][N];
    longint m_l0  [2][N];
    longint m_l1  [2][N];
    longint m_pr  [2][N];
    bit     m_val [2][N];
    int     m_act = 0;
    bit     m_swapping = 0;
    bit     m_armed = 1;
    longint e_sv, e_hit, e_idx, e_l0, e_l1, e_pr, e_ack, e_hc, e_mc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int a, hi, fld, idx;
        if (reset_i) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++) m_val[b][i] = 0;
            m_act = 0; m_swapping = 0; m_armed = 1;
            e_sv = 0; e_hit = 0; e_idx = 0; e_l0 = 0; e_l1 = 0; e_pr = 0;
            e_ack = 0; e_hc = 0; e_mc = 0;
            return;
        end
        a = m_act;
        e_sv = search_req_i;
        if (search_req_i) begin
            hi = -1;
            for (int i = 0; i < N; i++) begin
                if (m_val[a][i] && m_ref[a][i] == longint'(search_addr_i)) begin
                    hi = i;
                    break;
                end
            end
            if (hi >= 0) begin
                e_hit = 1; e_idx = hi;
                e_l0 = m_l0[a][hi]; e_l1 = m_l1[a][hi]; e_pr = m_pr[a][hi];
                if (e_hc < 64'hFFFF_FFFF) e_hc++;
            end else begin
                e_hit = 0; e_idx = 0; e_l0 = 0; e_l1 = 0; e_pr = 0;
                if (e_mc < 64'hFFFF_FFFF) e_mc++;
            end
        end
        if (wren_i) begin
            fld = int'(addr_i[BWE+1:BWE]);
            idx = int'(addr_i[BWE-1:0]);
            case (fld)
                0: begin
                    m_ref[1-a][idx] = longint'(data_i >> 2);
                    m_val[1-a][idx] = (idx < int'(phase_refs_i));
                end
                1: m_l0[1-a][idx] = longint'(data_i);
                2: m_l1[1-a][idx] = longint'(data_i);
                default: m_pr[1-a][idx] = longint'(data_i & 32'h1FF);
            endcase
        end
        e_ack = m_swapping;
        if (m_swapping) begin
            for (int i = 0; i < N; i++) m_val[a][i] = 0;
            m_act = 1 - a;
            e_hc = 0; e_mc = 0;
            m_swapping = 0;
            if (!swap_req_i) m_armed = 1;
        end else if (swap_req_i && m_armed) begin
            m_swapping = 1;
            m_armed = 0;
        end else if (!swap_req_i) begin
            m_armed = 1;
        end
    endtask

    task automatic compare();
        chk("search_valid", search_valid_o, e_sv);
        chk("hit", hit_o, e_hit);
        chk("hit_index", hit_index_o, e_idx);
        chk("lease0", lease0_o, e_l0);
        chk("lease1", lease1_o, e_l1);
        chk("prob", lease0_prob_o, e_pr);
        chk("swap_ack", swap_ack_o, e_ack);
        chk("active_bank", active_bank_o, longint'(m_act));
        chk("hit_count", hit_count_o, e_hc);
        chk("miss_count", miss_count_o, e_mc);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic write_word(input int fld, input int idx, input logic [31:0] d);
        wren_i = 1'b1;
        addr_i = {fld[1:0], idx[BWE-1:0]};
        data_i = d;
        step();
        wren_i = 1'b0;
    endtask

    task automatic write_entry(input int idx, input logic [31:0] ref_byte,
                               input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] pr);
        write_word(0, idx, ref_byte);
        write_word(1, idx, l0);
        write_word(2, idx, l1);
        write_word(3, idx, pr);
    endtask

    task automatic do_swap();
        bit seen;
        seen = 0;
        swap_req_i = 1'b1;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = swap_ack_o;
        end
        if (!seen) chk("swap_ack_timeout", 0, 1);
        swap_req_i = 1'b0;
        step();
    endtask

    task automatic search(input logic [29:0] a);
        search_req_i  = 1'b1;
        search_addr_i = a;
        step();
        search_req_i  = 1'b0;
    endtask

    initial begin
        int acks;
        logic [1:0] fld;
        logic [BWE-1:0] idx;

        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;

        // Give every entry of both banks defined contents, all invalid.
        phase_refs_i = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++)
                write_entry(i, $urandom(), $urandom(), $urandom(), $urandom());
            do_swap();
        end
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("reset_valid", search_valid_o, 0);
        chk("reset_hit", hit_o, 0);
        chk("reset_counts", {hit_count_o, miss_count_o}, 0);
        chk("reset_active", active_bank_o, 0);

        // Empty table: a lookup misses.
        search(30'h100);
        chk("t1_valid", search_valid_o, 1);
        chk("t1_hit", hit_o, 0);
        chk("t1_miss_count", miss_count_o, 1);
        chk("t1_active", active_bank_o, 0);

        // Single entry load and swap.
        phase_refs_i = 5'd8;
        write_entry(3, 32'h400, 32'd20, 32'd5, 32'd128);
        do_swap();
        chk("t2_counts_cleared", {hit_count_o, miss_count_o}, 0);
        search(30'h100);
        chk("t2_hit", hit_o, 1);
        chk("t2_idx", hit_index_o, 3);
        chk("t2_l0", lease0_o, 20);
        chk("t2_l1", lease1_o, 5);
        chk("t2_prob", lease0_prob_o, 128);
        chk("t2_hit_count", hit_count_o, 1);

        // Index beyond phase_refs is not valid.
        write_entry(9, 32'h800, 32'd7, 32'd7, 32'd7);
        do_swap();
        search(30'h200);
        chk("t3_hit", hit_o, 0);

        // Duplicate reference: lowest index wins.
        write_entry(2, 32'h1000, 32'd111, 32'd1, 32'd10);
        write_entry(6, 32'h1000, 32'd222, 32'd2, 32'd20);
        do_swap();
        search(30'h400);
        chk("t4_idx", hit_index_o, 2);
        chk("t4_l0", lease0_o, 111);

        // Lookups straddling the toggle.
        write_entry(1, 32'h1400, 32'd333, 32'd3, 32'd30);
        swap_req_i = 1'b1;
        step();
        search_req_i  = 1'b1;
        search_addr_i = 30'h400;
        step();
        chk("t5_old_bank_hit", hit_o, 1);
        chk("t5_old_bank_l0", lease0_o, 111);
        chk("t5_ack", swap_ack_o, 1);
        chk("t5_not_counted", hit_count_o, 0);
        swap_req_i = 1'b0;
        step();
        chk("t5_new_bank_miss", hit_o, 0);
        chk("t5_miss_count", miss_count_o, 1);
        search_addr_i = 30'h500;
        step();
        chk("t5_new_bank_hit", hit_o, 1);
        chk("t5_new_bank_idx", hit_index_o, 1);
        chk("t5_new_bank_l0", lease0_o, 333);
        search_req_i = 1'b0;
        do_swap();
        search(30'h400);
        chk("t5_stale_miss", hit_o, 0);

        // Held request yields one swap.
        acks = 0;
        swap_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            acks += int'(swap_ack_o);
        end
        swap_req_i = 1'b0;
        step();
        acks += int'(swap_ack_o);
        chk("t6_single_ack", acks, 1);

        // Reset while in SWAP drops the swap and the ack.
        chk("t7_pre_active", active_bank_o, 0);
        swap_req_i = 1'b1;
        step();
        swap_req_i = 1'b0;
        reset_i = 1'b1;
        step();
        chk("t7_active", active_bank_o, 0);
        chk("t7_ack", swap_ack_o, 0);
        chk("t7_counts", {hit_count_o, miss_count_o}, 0);
        reset_i = 1'b0;
        step();
        chk("t7_no_late_ack", swap_ack_o, 0);
        chk("t7_active_after", active_bank_o, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset_i = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) swap_req_i = ~swap_req_i;
            wren_i = 1'($urandom_range(0, 1));
            fld = 2'($urandom_range(0, 3));
            idx = BWE'($urandom_range(0, N - 1));
            addr_i = {fld, idx};
            if (fld == 2'd0)
                data_i = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            else
                data_i = $urandom();
            phase_refs_i = (BWE + 1)'($urandom_range(0, N));
            search_req_i = ($urandom_range(0, 3) != 0);
            search_addr_i = 30'($urandom_range(0, 9));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lease_lookup_table_dbuf.md
Name: lease_lookup_table_dbuf

Overview:
- Next-generation lease lookup table for the lease cache controller.
- Double-buffered: software/loader writes the next phase's entries into a shadow bank while the active bank serves lookups. A swap handshake then atomically exchanges the banks.
- Each entry carries lease0, lease1 and a lease0 probability.
- Lookups are pipelined with a 1-cycle registered response, and hit/miss statistics counters are provided.

Parameters:
- N_ENTRIES, 128, entries per bank (power of 2, >=2); BW_ENTRIES = clog2(N_ENTRIES).
- BW_REF_ADDR, 30, width of stored reference word address.
- BW_LEASE_REGISTER, 32, lease value width.
- BW_PROB, 9, lease0 probability field width.
- BW_COUNT, 32, statistics counter width.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- addr_i  in  BW_ENTRIES+2  shadow-bank write address: [top 2 bits] field select, [BW_ENTRIES-1:0] entry index
- wren_i  in  1  write data_i into shadow bank at addr_i
- data_i  in  32  write data (word)
- phase_refs_i  in  BW_ENTRIES+1  number of valid references in the phase being loaded
- swap_req_i  in  1  request shadow/active exchange (level, held until ack)
- swap_ack_o  out  1  1-cycle pulse: swap performed
- search_req_i  in  1  lookup request
- search_addr_i  in  BW_REF_ADDR  word address of the requesting ld/st
- search_valid_o  out  1  response valid
- hit_o  out  1  match in active bank
- hit_index_o  out  BW_ENTRIES  matching entry index
- lease0_o  out  BW_LEASE_REGISTER  matched lease0
- lease1_o  out  BW_LEASE_REGISTER  matched lease1
- lease0_prob_o  out  BW_PROB  matched lease0 probability
- active_bank_o  out  1  index of active bank
- hit_count_o  out  BW_COUNT  lookups that hit since reset/swap
- miss_count_o  out  BW_COUNT  lookups that missed since reset/swap

Behaviour:
- Reset (sync, active-high):
  - all valid bits of both banks = 0; active_bank_o = 0.
  - swap_ack_o, search_valid_o, hit_o = 0; hit_index_o, lease*, prob outputs = 0.
  - counters = 0.
  - Entry storage need not be cleared.
  - Reset mid-lookup or mid-swap: the in-flight response and ack are dropped.
- Writes always target the shadow bank (!active_bank_o). Field select:
  - 00: ref_addr[idx] <= data_i[BW_REF_ADDR+1:2]; valid[idx] <= (idx < phase_refs_i).
  - 01: lease0[idx] <= data_i[BW_LEASE_REGISTER-1:0].
  - 10: lease1[idx] <= data_i[BW_LEASE_REGISTER-1:0].
  - 11: prob[idx] <= data_i[BW_PROB-1:0].
- Lookup, latency 1:
  - Request accepted every cycle with search_req_i=1; no backpressure.
  - Next cycle: search_valid_o=1 with the result registered from the active bank as it stood in the request cycle.
  - Match = valid & (ref_addr == search_addr_i). Multiple matches: the lowest index wins.
  - Miss: hit_o=0 and hit_index_o/lease0_o/lease1_o/lease0_prob_o=0.
  - search_req_i=0: search_valid_o=0 and the data outputs hold their previous values.
- Swap state machine, states IDLE and SWAP:
  - IDLE -> SWAP when swap_req_i=1.
  - In SWAP (exactly one cycle): active_bank_o toggles; all valid bits of the new shadow bank (old active) are cleared; hit_count_o and miss_count_o are cleared to 0; swap_ack_o=1 the following cycle; return to IDLE.
  - swap_req_i still high after the ack: the next swap is taken only after swap_req_i has been seen low for at least 1 cycle (edge-qualified).
- Simultaneous events:
  - Write in the same cycle the bank toggles: the write lands in the pre-toggle shadow bank, i.e. the new active bank.
  - Lookup in the toggle cycle: uses the pre-toggle active bank.
  - Lookup in the cycle after the toggle: uses the new bank.
  - A response that completes in the toggle cycle is not counted in the cleared counters.
- Counters:
  - Each search_valid_o increments hit_count_o or miss_count_o.
  - Both saturate at all-ones (no wrap).
- A stored reference address of 0 with valid=1 is legal; validity comes only from phase_refs_i.

Test Plan:
- Reset, then search 0x100 -> one cycle later search_valid_o=1, hit_o=0, miss_count_o=1, active_bank_o=0.
- Load shadow idx 3: ref byte addr 0x400, lease0=20, lease1=5, prob=128, with phase_refs_i=8. Swap. Search 0x100 -> hit_o=1, hit_index_o=3, lease0_o=20, lease1_o=5, lease0_prob_o=128, hit_count_o=1 after the swap cleared it.
- Write ref at idx 9 with phase_refs_i=8, swap, search that address -> hit_o=0, since the entry is not valid.
- Same ref at idx 2 and idx 6 with different leases -> idx 2 lease returned.
- Search issued in the toggle cycle -> old-bank result. Search the next cycle -> new-bank result. The old active bank's entries miss after a second swap unless reloaded.
- Hold swap_req_i high for 5 cycles -> exactly one swap_ack_o pulse. Assert reset during SWAP -> active_bank_o=0, no ack, counters 0.
